// File: rtl/keypad_pkg.sv
// Shared types and default parameter values for the matrix keypad scanner.
// The counter-width helper keeps every counter at least one bit wide, even when its maximum is zero.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  localparam int unsigned KP_ROWS            = 4;
  localparam int unsigned KP_COLS            = 4;
  localparam int unsigned KP_SCAN_CYCLES     = 4;
  localparam int unsigned KP_DEBOUNCE_CYCLES = 8;
  localparam int unsigned KP_REPEAT_CYCLES   = 0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    if (max_val >= 1) begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous column inputs.
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-hot row drive, synchronised column sense, press/release
// debounce, multi-key flagging and optional auto-repeat, with all outputs registered.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = KP_ROWS,
  parameter int unsigned COLS            = KP_COLS,
  parameter int unsigned SCAN_CYCLES     = KP_SCAN_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = KP_REPEAT_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COLS-1:0]           cols_raw,
  output logic [ROWS-1:0]           rows,
  output logic [$clog2(ROWS)-1:0]   key_row,
  output logic [$clog2(COLS)-1:0]   key_col,
  output logic                      key_valid,
  output logic                      key_held,
  output logic                      key_release,
  output logic                      multi_key
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned DW_W = cnt_width(SCAN_CYCLES - 1);
  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RP_W = cnt_width(REPEAT_CYCLES);

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST    = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW0       = ROWS'(1);
  localparam logic [COLS-1:0] COL0       = COLS'(1);
  localparam logic [CW:0]     CNT_ONE    = (CW + 1)'(1);

  logic [COLS-1:0] cols_s;

  kp_state_e       state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [RP_W-1:0] rep_q, rep_d;
  logic [CW-1:0]   cand_col_q, cand_col_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [RW-1:0]   key_row_q, key_row_d;
  logic [CW-1:0]   key_col_q, key_col_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            key_release_q, key_release_d;
  logic            multi_q, multi_d;

  logic [CW:0]     ones;
  logic [CW-1:0]   col_idx;
  logic [COLS-1:0] cand_onehot;
  logic [RW-1:0]   row_next;

  keypad_sync #(
    .WIDTH (COLS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cols_raw),
    .q_o   (cols_s)
  );

  // Column population count and index of the highest set column.
  always_comb begin
    ones    = '0;
    col_idx = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      ones = ones + {{CW{1'b0}}, cols_s[i]};
      if (cols_s[i]) begin
        col_idx = CW'(i);
      end
    end
  end

  assign cand_onehot = COL0 << cand_col_q;
  assign row_next    = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    dwell_d       = dwell_q;
    db_d          = db_q;
    rep_d         = rep_q;
    cand_col_d    = cand_col_q;
    key_row_d     = key_row_q;
    key_col_d     = key_col_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    multi_d       = multi_q;

    case (state_q)
      SCAN: begin
        key_held_d = 1'b0;
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          multi_d = (ones > CNT_ONE);
          if (ones == CNT_ONE) begin
            state_d    = PRESS_DB;
            cand_col_d = col_idx;
            db_d       = '0;
          end else begin
            row_d = row_next;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end

      PRESS_DB: begin
        multi_d = 1'b0;
        if (cols_s == cand_onehot) begin
          if (db_q == DB_LAST) begin
            state_d     = HELD;
            db_d        = '0;
            rep_d       = '0;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_row_d   = row_q;
            key_col_d   = cand_col_q;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          state_d = SCAN;
          db_d    = '0;
          dwell_d = '0;
          row_d   = row_next;
        end
      end

      HELD: begin
        multi_d = (cols_s != '0) && (cols_s != cand_onehot);
        if (cols_s == '0) begin
          state_d = RELEASE_DB;
          db_d    = '0;
        end else if (REPEAT_CYCLES > 0) begin
          if (rep_q == RP_LAST) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + RP_W'(1);
          end
        end
      end

      RELEASE_DB: begin
        multi_d = 1'b0;
        if (cols_s == '0) begin
          if (db_q == DB_LAST) begin
            state_d       = SCAN;
            db_d          = '0;
            dwell_d       = '0;
            row_d         = row_next;
            key_held_d    = 1'b0;
            key_release_d = 1'b1;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          // Any activity before the release completes resumes HELD; HELD flags a wrong column.
          state_d = HELD;
          db_d    = '0;
          rep_d   = '0;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    rows_d = ROW0 << row_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      row_q         <= '0;
      dwell_q       <= '0;
      db_q          <= '0;
      rep_q         <= '0;
      cand_col_q    <= '0;
      rows_q        <= ROW0;
      key_row_q     <= '0;
      key_col_q     <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      db_q          <= db_d;
      rep_q         <= rep_d;
      cand_col_q    <= cand_col_d;
      rows_q        <= rows_d;
      key_row_q     <= key_row_d;
      key_col_q     <= key_col_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
      multi_q       <= multi_d;
    end
  end

  assign rows        = rows_q;
  assign key_row     = key_row_q;
  assign key_col     = key_col_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;
  assign multi_key   = multi_q;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner with row drive, column synchronisation, per-key debounce, multi-key rejection, optional auto-repeat and release reporting. It sits between the keypad pins and the display/decode logic. It replaces ad-hoc row FSMs with a single block that emits a clean one-cycle key event carrying the row/column index.

## Interface
- ROWS, 4, number of driven rows (≥2)
- COLS, 4, number of sensed columns (≥2)
- SCAN_CYCLES, 4, clocks each row is driven during scan (≥3)
- DEBOUNCE_CYCLES, 8, consecutive stable clocks needed for press and for release (≥1)
- REPEAT_CYCLES, 0, held-key repeat period in clocks; 0 disables repeat
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cols_raw  in  COLS  asynchronous column inputs, active-high
- rows  out  ROWS  one-hot row drive, active-high
- key_row  out  $clog2(ROWS)  row index of last accepted key
- key_col  out  $clog2(COLS)  column index of last accepted key
- key_valid  out  1  one-cycle pulse: press accepted or repeat
- key_held  out  1  level: accepted key still pressed
- key_release  out  1  one-cycle pulse: debounced release
- multi_key  out  1  level: >1 column seen on active row in current SCAN dwell or during HELD

## Operation
- cols_raw passes a 2-flop synchroniser → cols_s. All decisions use cols_s only.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: drive row r for SCAN_CYCLES; sample cols_s on the last dwell cycle. Zero → r advances (ROWS-1 wraps to 0). Exactly one bit set → capture r and column index, enter PRESS_DB, freeze rows. More than one bit → multi_key=1 for next dwell, no capture, advance r.
- PRESS_DB: counter increments each cycle cols_s equals captured one-hot; any mismatch → back to SCAN at r+1, counter cleared. Counter reaching DEBOUNCE_CYCLES → key_row/key_col update, key_valid pulse, enter HELD.
- HELD: key_held=1. cols_s all-zero → RELEASE_DB. Nonzero mismatch → multi_key=1, stay HELD. REPEAT_CYCLES>0: repeat counter pulses key_valid every REPEAT_CYCLES cycles in HELD, restarting on HELD entry.
- RELEASE_DB: key_held stays 1; counts consecutive all-zero cycles. Reaching DEBOUNCE_CYCLES → key_release pulse, key_held=0, SCAN at r+1. Match before that → HELD without pulse, repeat counter restarted.
- Reset mid-operation: all state cleared next edge; no key_release emitted.
- key_row/key_col hold their value until the next accepted press.

## Timing
- Reset values: rows=1 (row 0), key_row=0, key_col=0, key_valid=0, key_held=0, key_release=0, multi_key=0; all counters and sync flops 0; state SCAN.
- All outputs registered.
- Synchroniser latency 2 cycles; SCAN_CYCLES≥3 guarantees the sample reflects the current row.
- key_valid high the cycle after the DEBOUNCE_CYCLES-th consecutive matching cycle; press-to-valid ≤ 2 + ROWS·SCAN_CYCLES + DEBOUNCE_CYCLES + 1 clocks.
- key_release and key_held fall on the same cycle.
- key_valid and key_release never coincide.

## Structure
- Package keypad_pkg: state enum typedef (SCAN, PRESS_DB, HELD, RELEASE_DB) and default parameter constants.
- Sub-module keypad_sync: parametrised-width 2-flop synchroniser with synchronous reset.
- Counters sized with $clog2 of their maxima + 1.

## Test plan
- Reset, no key → rows cycles 0001→0010→0100→1000→0001, each held 4 cycles; no pulses.
- Press row 2/col 1 held 40 cycles → single key_valid, key_row=2, key_col=1, key_held=1; release → key_release after 8 zero cycles.
- Bounce: col toggles every 3 cycles for 30 cycles then steady → exactly one key_valid, only after steady.
- Two columns high on row 1 → multi_key=1, no key_valid, scanning continues.
- REPEAT_CYCLES=16, hold 100 cycles after accept → key_valid at accept then every 16 cycles (7 pulses total).
- Reset asserted while HELD → outputs return to reset values, no key_release.
